// File: rtl/sprite_palette_pkg.sv
// Shared types and constants for the sprite palette bank: fade-state enum,
// brightness range and a default-width packed RGB entry.
package sprite_palette_pkg;

    localparam int BRIGHT_MAX = 16;
    localparam int BRIGHT_W   = 5;
    localparam int CH_W_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } fade_state_e;

    typedef struct packed {
        logic [CH_W_DEF-1:0] r;
        logic [CH_W_DEF-1:0] g;
        logic [CH_W_DEF-1:0] b;
    } rgb_t;

endpackage

// File: rtl/sprite_palette_bank_if.sv
// Bundle of the palette bank's lookup, write and fade signals; the master
// modport drives requests, the slave modport is the palette bank side.
interface sprite_palette_bank_if #(
    parameter int INDEX_W = 4,
    parameter int NUM_PAL = 4,
    parameter int CH_W    = 4
) ();
    logic                       rd_valid;
    logic [$clog2(NUM_PAL)-1:0] rd_pal;
    logic [INDEX_W-1:0]         rd_index;
    logic                       wr_en;
    logic [$clog2(NUM_PAL)-1:0] wr_pal;
    logic [INDEX_W-1:0]         wr_index;
    logic [3*CH_W-1:0]          wr_rgb;
    logic                       frame_tick;
    logic                       fade_start;
    logic                       fade_dir;
    logic [CH_W-1:0]            red;
    logic [CH_W-1:0]            green;
    logic [CH_W-1:0]            blue;
    logic                       out_valid;
    logic                       transparent;
    logic                       fade_busy;
    logic                       fade_done;

    modport master (
        output rd_valid, rd_pal, rd_index, wr_en, wr_pal, wr_index, wr_rgb,
               frame_tick, fade_start, fade_dir,
        input  red, green, blue, out_valid, transparent, fade_busy, fade_done
    );

    modport slave (
        input  rd_valid, rd_pal, rd_index, wr_en, wr_pal, wr_index, wr_rgb,
               frame_tick, fade_start, fade_dir,
        output red, green, blue, out_valid, transparent, fade_busy, fade_done
    );
endinterface

// File: rtl/palette_scale.sv
// One colour channel scaled by brightness: (ch * b) >> 4, with b in 0..16.
module palette_scale
    import sprite_palette_pkg::*;
#(
    parameter int CH_W = 4
) (
    input  logic [CH_W-1:0]     ch,
    input  logic [BRIGHT_W-1:0] bright,
    output logic [CH_W-1:0]     scaled
);
    logic [CH_W+4:0] product;
    logic            unused_product_msb;

    assign product = {5'd0, ch} * {{CH_W{1'b0}}, bright};
    // Top bit is only reachable above b=16, so it is dropped by the shift-and-truncate.
    assign scaled             = product[CH_W+3:4];
    assign unused_product_msb = product[CH_W+4];
endmodule

// File: rtl/sprite_palette_bank.sv
// Multi-palette colour lookup with a 2-stage pipeline and frame-stepped fade.
// The fade FSM is built only when PALETTE_FADE_EN is defined; otherwise b=16.
module sprite_palette_bank
    import sprite_palette_pkg::*;
#(
    parameter int INDEX_W = 4,
    parameter int NUM_PAL = 4,
    parameter int CH_W    = 4
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       rd_valid,
    input  logic [$clog2(NUM_PAL)-1:0] rd_pal,
    input  logic [INDEX_W-1:0]         rd_index,
    input  logic                       wr_en,
    input  logic [$clog2(NUM_PAL)-1:0] wr_pal,
    input  logic [INDEX_W-1:0]         wr_index,
    input  logic [3*CH_W-1:0]          wr_rgb,
    input  logic                       frame_tick,
    input  logic                       fade_start,
    input  logic                       fade_dir,
    output logic [CH_W-1:0]            red,
    output logic [CH_W-1:0]            green,
    output logic [CH_W-1:0]            blue,
    output logic                       out_valid,
    output logic                       transparent,
    output logic                       fade_busy,
    output logic                       fade_done
);
    localparam int PAL_W  = $clog2(NUM_PAL);
    localparam int ADDR_W = PAL_W + INDEX_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int RGB_W  = 3 * CH_W;

    logic [RGB_W-1:0] mem_q [DEPTH];
    logic [RGB_W-1:0] mem_d [DEPTH];
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;

    logic             s1_valid_q, s1_valid_d;
    logic [RGB_W-1:0] s1_rgb_q, s1_rgb_d;
    logic             s1_transp_q, s1_transp_d;
    logic             out_valid_q, out_valid_d;
    logic             transparent_q, transparent_d;
    logic [RGB_W-1:0] rgb_out_q, rgb_out_d;
    logic [RGB_W-1:0] scaled_rgb;
    logic [BRIGHT_W-1:0] bright;

    assign rd_addr = {rd_pal, rd_index};
    assign wr_addr = {wr_pal, wr_index};

    // Stage 1 samples mem_q before this edge's write lands, giving read-first behaviour.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_rgb;
        end
        s1_valid_d    = rd_valid;
        s1_rgb_d      = mem_q[rd_addr];
        s1_transp_d   = (rd_index == '0);
        out_valid_d   = s1_valid_q;
        transparent_d = s1_valid_q & s1_transp_q;
        rgb_out_d     = s1_valid_q ? scaled_rgb : rgb_out_q;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            s1_valid_q    <= 1'b0;
            s1_rgb_q      <= '0;
            s1_transp_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            transparent_q <= 1'b0;
            rgb_out_q     <= '0;
        end else begin
            mem_q         <= mem_d;
            s1_valid_q    <= s1_valid_d;
            s1_rgb_q      <= s1_rgb_d;
            s1_transp_q   <= s1_transp_d;
            out_valid_q   <= out_valid_d;
            transparent_q <= transparent_d;
            rgb_out_q     <= rgb_out_d;
        end
    end

    // Channel 0 is B, 1 is G, 2 is R, matching the {R,G,B} entry layout.
    for (genvar gi = 0; gi < 3; gi++) begin : g_scale
        palette_scale #(
            .CH_W(CH_W)
        ) u_scale (
            .ch    (s1_rgb_q[gi*CH_W +: CH_W]),
            .bright(bright),
            .scaled(scaled_rgb[gi*CH_W +: CH_W])
        );
    end

    assign red         = rgb_out_q[2*CH_W +: CH_W];
    assign green       = rgb_out_q[CH_W +: CH_W];
    assign blue        = rgb_out_q[0 +: CH_W];
    assign out_valid   = out_valid_q;
    assign transparent = transparent_q;

`ifdef PALETTE_FADE_EN
    fade_state_e         state_q, state_d;
    logic [BRIGHT_W-1:0] bright_q, bright_d;
    logic                fade_busy_q, fade_busy_d;
    logic                fade_done_q, fade_done_d;

    // A start in IDLE only changes state; a coincident frame_tick is not applied to b.
    always_comb begin
        state_d     = state_q;
        bright_d    = bright_q;
        fade_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (fade_start) begin
                    state_d = fade_dir ? FADE_IN : FADE_OUT;
                end
            end
            FADE_OUT: begin
                if (frame_tick) begin
                    if (bright_q != '0) begin
                        bright_d = bright_q - 5'd1;
                    end
                    if (bright_q <= 5'd1) begin
                        state_d     = IDLE;
                        fade_done_d = 1'b1;
                    end
                end
            end
            FADE_IN: begin
                if (frame_tick) begin
                    if (bright_q < 5'(BRIGHT_MAX)) begin
                        bright_d = bright_q + 5'd1;
                    end
                    if (bright_q >= 5'(BRIGHT_MAX - 1)) begin
                        state_d     = IDLE;
                        fade_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        fade_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            bright_q    <= 5'(BRIGHT_MAX);
            fade_busy_q <= 1'b0;
            fade_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bright_q    <= bright_d;
            fade_busy_q <= fade_busy_d;
            fade_done_q <= fade_done_d;
        end
    end

    assign bright    = bright_q;
    assign fade_busy = fade_busy_q;
    assign fade_done = fade_done_q;
`else
    logic unused_fade_inputs;

    assign unused_fade_inputs = ^{fade_start, fade_dir, frame_tick};
    assign bright             = 5'(BRIGHT_MAX);
    assign fade_busy          = 1'b0;
    assign fade_done          = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed self-checking bench for sprite_palette_bank; fade scenarios run
// when PALETTE_FADE_EN is defined, the fixed-brightness build scenario otherwise.
module tb_sprite_palette_bank;
    import sprite_palette_pkg::*;

    logic Clk = 1'b0;
    logic Reset_n;
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;

    sprite_palette_bank_if #(.INDEX_W(4), .NUM_PAL(4), .CH_W(4)) ifc ();

    sprite_palette_bank #(.INDEX_W(4), .NUM_PAL(4), .CH_W(4)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .rd_valid   (ifc.rd_valid),
        .rd_pal     (ifc.rd_pal),
        .rd_index   (ifc.rd_index),
        .wr_en      (ifc.wr_en),
        .wr_pal     (ifc.wr_pal),
        .wr_index   (ifc.wr_index),
        .wr_rgb     (ifc.wr_rgb),
        .frame_tick (ifc.frame_tick),
        .fade_start (ifc.fade_start),
        .fade_dir   (ifc.fade_dir),
        .red        (ifc.red),
        .green      (ifc.green),
        .blue       (ifc.blue),
        .out_valid  (ifc.out_valid),
        .transparent(ifc.transparent),
        .fade_busy  (ifc.fade_busy),
        .fade_done  (ifc.fade_done)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (ifc.fade_done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_entry(input logic [1:0] pal, input logic [3:0] idx, input logic [11:0] rgb);
        ifc.wr_en = 1'b1; ifc.wr_pal = pal; ifc.wr_index = idx; ifc.wr_rgb = rgb;
        tick();
        ifc.wr_en = 1'b0;
    endtask

    task automatic do_lookup(input logic [1:0] pal, input logic [3:0] idx,
                             output logic [11:0] rgb_o, output logic vld_o);
        ifc.rd_valid = 1'b1; ifc.rd_pal = pal; ifc.rd_index = idx;
        tick();
        ifc.rd_valid = 1'b0;
        tick();
        rgb_o = {ifc.red, ifc.green, ifc.blue};
        vld_o = ifc.out_valid;
    endtask

    task automatic pulse_frame();
        ifc.frame_tick = 1'b1;
        tick();
        ifc.frame_tick = 1'b0;
        tick();
    endtask

    function automatic logic [11:0] stream_val(input int i);
        logic [3:0] a, b, c;
        a = 4'(i); b = 4'(15 - i); c = 4'(i ^ 3);
        return {a, b, c};
    endfunction

    task automatic test_reset();
        logic [11:0] rgb; logic vld;
        Reset_n = 1'b0;
        ifc.rd_valid = 1'b1; ifc.rd_pal = 2'd0; ifc.rd_index = 4'd5;
        repeat (3) tick();
        checks++;
        if ({ifc.out_valid, ifc.transparent, ifc.fade_busy, ifc.fade_done} !== 4'b0000 ||
            {ifc.red, ifc.green, ifc.blue} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: got v/t/b/d=%b rgb=%h expected 0000 rgb=000",
                     {ifc.out_valid, ifc.transparent, ifc.fade_busy, ifc.fade_done},
                     {ifc.red, ifc.green, ifc.blue});
        end
        ifc.rd_valid = 1'b0;
        Reset_n = 1'b1;
        tick();
        ifc.rd_valid = 1'b1;
        tick();
        ifc.rd_valid = 1'b0;
        checks++;
        if (ifc.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_not_1: got out_valid=%b expected 0", ifc.out_valid);
        end
        tick();
        rgb = {ifc.red, ifc.green, ifc.blue}; vld = ifc.out_valid;
        checks++;
        if (vld !== 1'b1 || rgb !== 12'h000 || ifc.transparent !== 1'b0) begin
            failures++;
            $display("FAIL reset_read: got v=%b rgb=%h t=%b expected v=1 rgb=000 t=0",
                     vld, rgb, ifc.transparent);
        end
        $display("reset: v=%b rgb=%h", vld, rgb);
    endtask

    task automatic test_write_read();
        logic [11:0] rgb;
        ifc.wr_en = 1'b1; ifc.wr_pal = 2'd2; ifc.wr_index = 4'd7; ifc.wr_rgb = 12'hABC;
        ifc.rd_valid = 1'b1; ifc.rd_pal = 2'd2; ifc.rd_index = 4'd7;
        tick();
        ifc.wr_en = 1'b0;
        tick();
        ifc.rd_valid = 1'b0;
        rgb = {ifc.red, ifc.green, ifc.blue};
        checks++;
        if (ifc.out_valid !== 1'b1 || rgb !== 12'h000) begin
            failures++;
            $display("FAIL read_first: got v=%b rgb=%h expected v=1 rgb=000", ifc.out_valid, rgb);
        end
        $display("write_read same-cycle: rgb=%h", rgb);
        tick();
        rgb = {ifc.red, ifc.green, ifc.blue};
        checks++;
        if (ifc.out_valid !== 1'b1 || rgb !== 12'hABC) begin
            failures++;
            $display("FAIL write_then_read: got v=%b rgb=%h expected v=1 rgb=abc", ifc.out_valid, rgb);
        end
        $display("write_read next-cycle: rgb=%h", rgb);
        tick();
        rgb = {ifc.red, ifc.green, ifc.blue};
        checks++;
        if (ifc.out_valid !== 1'b0 || rgb !== 12'hABC) begin
            failures++;
            $display("FAIL hold_when_idle: got v=%b rgb=%h expected v=0 rgb=abc", ifc.out_valid, rgb);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] rgb;
        for (int i = 0; i < 16; i++) write_entry(2'd1, 4'(i), stream_val(i));
        for (int k = 0; k <= 16; k++) begin
            ifc.rd_valid = (k < 16); ifc.rd_pal = 2'd1; ifc.rd_index = 4'(k);
            tick();
            if (k >= 1) begin
                rgb = {ifc.red, ifc.green, ifc.blue};
                checks++;
                if (ifc.out_valid !== 1'b1 || rgb !== stream_val(k - 1) ||
                    ifc.transparent !== (k == 1)) begin
                    failures++;
                    $display("FAIL stream_%0d: got v=%b rgb=%h t=%b expected v=1 rgb=%h t=%b",
                             k - 1, ifc.out_valid, rgb, ifc.transparent, stream_val(k - 1), (k == 1));
                end
                $display("stream idx=%0d rgb=%h t=%b", k - 1, rgb, ifc.transparent);
            end
        end
        ifc.rd_valid = 1'b0;
        tick();
        checks++;
        if (ifc.out_valid !== 1'b0 || ifc.transparent !== 1'b0) begin
            failures++;
            $display("FAIL stream_end: got v=%b t=%b expected v=0 t=0", ifc.out_valid, ifc.transparent);
        end
    endtask

`ifdef PALETTE_FADE_EN
    task automatic test_fade_out();
        logic [11:0] rgb; logic vld;
        write_entry(2'd0, 4'd1, 12'hFFF);
        done_cnt = 0;
        ifc.fade_dir = 1'b0; ifc.fade_start = 1'b1;
        tick();
        ifc.fade_start = 1'b0;
        checks++;
        if (ifc.fade_busy !== 1'b1) begin
            failures++;
            $display("FAIL fade_out_busy: got %b expected 1", ifc.fade_busy);
        end
        repeat (8) pulse_frame();
        do_lookup(2'd0, 4'd1, rgb, vld);
        checks++;
        if (vld !== 1'b1 || rgb !== 12'h777) begin
            failures++;
            $display("FAIL fade_out_half: got v=%b rgb=%h expected v=1 rgb=777", vld, rgb);
        end
        $display("fade_out 8 ticks: rgb=%h", rgb);
        repeat (7) pulse_frame();
        ifc.frame_tick = 1'b1;
        tick();
        ifc.frame_tick = 1'b0;
        checks++;
        if (ifc.fade_done !== 1'b1 || ifc.fade_busy !== 1'b0) begin
            failures++;
            $display("FAIL fade_out_done: got done=%b busy=%b expected done=1 busy=0",
                     ifc.fade_done, ifc.fade_busy);
        end
        tick();
        checks++;
        if (ifc.fade_done !== 1'b0) begin
            failures++;
            $display("FAIL fade_done_width: got %b expected 0", ifc.fade_done);
        end
        do_lookup(2'd0, 4'd1, rgb, vld);
        checks++;
        if (rgb !== 12'h000 || done_cnt != 1) begin
            failures++;
            $display("FAIL fade_out_black: got rgb=%h done_pulses=%0d expected rgb=000 done_pulses=1",
                     rgb, done_cnt);
        end
        $display("fade_out 16 ticks: rgb=%h done_pulses=%0d", rgb, done_cnt);
    endtask

    task automatic test_busy_collision();
        logic [11:0] rgb; logic vld;
        done_cnt = 0;
        ifc.fade_dir = 1'b1; ifc.fade_start = 1'b1; ifc.frame_tick = 1'b1;
        tick();
        ifc.fade_start = 1'b0; ifc.frame_tick = 1'b0;
        do_lookup(2'd0, 4'd1, rgb, vld);
        checks++;
        if (ifc.fade_busy !== 1'b1 || rgb !== 12'h000) begin
            failures++;
            $display("FAIL collision: got busy=%b rgb=%h expected busy=1 rgb=000", ifc.fade_busy, rgb);
        end
        ifc.fade_dir = 1'b0; ifc.fade_start = 1'b1;
        tick();
        ifc.fade_start = 1'b0;
        repeat (4) pulse_frame();
        do_lookup(2'd0, 4'd1, rgb, vld);
        checks++;
        if (ifc.fade_busy !== 1'b1 || rgb !== 12'h333) begin
            failures++;
            $display("FAIL start_while_busy: got busy=%b rgb=%h expected busy=1 rgb=333", ifc.fade_busy, rgb);
        end
        $display("fade_in 4 ticks: rgb=%h", rgb);
        repeat (12) pulse_frame();
        do_lookup(2'd0, 4'd1, rgb, vld);
        checks++;
        if (ifc.fade_busy !== 1'b0 || rgb !== 12'hFFF || done_cnt != 1) begin
            failures++;
            $display("FAIL fade_in_end: got busy=%b rgb=%h done_pulses=%0d expected busy=0 rgb=fff done_pulses=1",
                     ifc.fade_busy, rgb, done_cnt);
        end
        $display("fade_in 16 ticks: rgb=%h", rgb);
    endtask

    task automatic test_at_target();
        logic [11:0] rgb; logic vld;
        ifc.fade_dir = 1'b1; ifc.fade_start = 1'b1;
        tick();
        ifc.fade_start = 1'b0;
        checks++;
        if (ifc.fade_busy !== 1'b1) begin
            failures++;
            $display("FAIL target_busy: got %b expected 1", ifc.fade_busy);
        end
        ifc.frame_tick = 1'b1;
        tick();
        ifc.frame_tick = 1'b0;
        checks++;
        if (ifc.fade_done !== 1'b1 || ifc.fade_busy !== 1'b0) begin
            failures++;
            $display("FAIL target_done: got done=%b busy=%b expected done=1 busy=0", ifc.fade_done, ifc.fade_busy);
        end
        do_lookup(2'd0, 4'd1, rgb, vld);
        checks++;
        if (rgb !== 12'hFFF) begin
            failures++;
            $display("FAIL target_bright: got rgb=%h expected fff", rgb);
        end
        $display("at_target fade_in: rgb=%h", rgb);
    endtask
`else
    task automatic test_no_fade();
        logic [11:0] rgb; logic vld; int seen;
        seen = 0;
        write_entry(2'd0, 4'd1, 12'hFFF);
        ifc.fade_dir = 1'b0; ifc.fade_start = 1'b1;
        tick();
        ifc.fade_start = 1'b0;
        if (ifc.fade_busy !== 1'b0 || ifc.fade_done !== 1'b0) seen++;
        for (int i = 0; i < 20; i++) begin
            ifc.frame_tick = 1'b1;
            tick();
            if (ifc.fade_busy !== 1'b0 || ifc.fade_done !== 1'b0) seen++;
            ifc.frame_tick = 1'b0;
            tick();
            if (ifc.fade_busy !== 1'b0 || ifc.fade_done !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL no_fade_flags: got %0d cycles with busy/done set expected 0", seen);
        end
        do_lookup(2'd0, 4'd1, rgb, vld);
        checks++;
        if (vld !== 1'b1 || rgb !== 12'hFFF) begin
            failures++;
            $display("FAIL no_fade_colour: got v=%b rgb=%h expected v=1 rgb=fff", vld, rgb);
        end
        $display("no_fade 20 ticks: rgb=%h", rgb);
    endtask
`endif

    task automatic test_reset_mid();
        logic [11:0] rgb; logic vld;
        write_entry(2'd0, 4'd1, 12'hFFF);
        ifc.fade_dir = 1'b0; ifc.fade_start = 1'b1;
        tick();
        ifc.fade_start = 1'b0;
        repeat (4) pulse_frame();
        ifc.rd_valid = 1'b1; ifc.rd_pal = 2'd0; ifc.rd_index = 4'd0;
        tick();
        ifc.rd_valid = 1'b0;
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        tick();
        checks++;
        if (ifc.out_valid !== 1'b0 || ifc.fade_busy !== 1'b0 || ifc.transparent !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got v=%b busy=%b t=%b expected 0 0 0",
                     ifc.out_valid, ifc.fade_busy, ifc.transparent);
        end
        do_lookup(2'd0, 4'd1, rgb, vld);
        checks++;
        if (rgb !== 12'h000) begin
            failures++;
            $display("FAIL reset_clears_mem: got rgb=%h expected 000", rgb);
        end
        write_entry(2'd0, 4'd1, 12'hFFF);
        do_lookup(2'd0, 4'd1, rgb, vld);
        checks++;
        if (rgb !== 12'hFFF) begin
            failures++;
            $display("FAIL reset_restores_b: got rgb=%h expected fff", rgb);
        end
        $display("reset_mid: rgb=%h", rgb);
    endtask

    initial begin
        ifc.rd_valid = 1'b0; ifc.rd_pal = '0; ifc.rd_index = '0;
        ifc.wr_en = 1'b0; ifc.wr_pal = '0; ifc.wr_index = '0; ifc.wr_rgb = '0;
        ifc.frame_tick = 1'b0; ifc.fade_start = 1'b0; ifc.fade_dir = 1'b0;
        Reset_n = 1'b0;
        test_reset();
        test_write_read();
        test_back_to_back();
`ifdef PALETTE_FADE_EN
        test_fade_out();
        test_busy_collision();
        test_at_target();
`else
        test_no_fade();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sprite_palette_bank.md
SPRITE_PALETTE_BANK -- requirements
Module: sprite_palette_bank

Interface
REQ-001 SHALL have parameter INDEX_W, default 4: colour-index width; 2**INDEX_W entries per palette.
REQ-002 SHALL have parameter NUM_PAL, default 4: number of palettes, power of two and at least 2.
REQ-003 SHALL have parameter CH_W, default 4: width of each R/G/B channel.
REQ-004 SHALL have port Clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port rd_valid, input, 1: lookup request.
REQ-007 SHALL have port rd_pal, input, $clog2(NUM_PAL): palette select for the lookup.
REQ-008 SHALL have port rd_index, input, INDEX_W: colour index for the lookup.
REQ-009 SHALL have port wr_en, input, 1: palette write strobe.
REQ-010 SHALL have ports wr_pal and wr_index, inputs, same widths as rd_pal and rd_index: write address.
REQ-011 SHALL have port wr_rgb, input, 3*CH_W: write data as {R,G,B}.
REQ-012 SHALL have port frame_tick, input, 1: one-cycle pulse per video frame.
REQ-013 SHALL have ports fade_start and fade_dir, inputs, 1 each: fade_dir 0 = fade out, 1 = fade in.
REQ-014 SHALL have ports red, green and blue, outputs, CH_W each: looked-up colour.
REQ-015 SHALL have ports out_valid and transparent, outputs, 1 each: output qualifier and index-0 flag.
REQ-016 SHALL have ports fade_busy and fade_done, outputs, 1 each.

Function
REQ-017 Storage SHALL be NUM_PAL x 2**INDEX_W entries of 3*CH_W bits, held in registers.
REQ-018 Lookup latency SHALL be exactly 2 cycles: stage 1 registers the entry; stage 2 applies brightness.
- out_valid = rd_valid delayed by 2 cycles.
- Back-to-back requests are accepted every cycle.
REQ-019 red, green and blue SHALL hold their last value when out_valid=0.
REQ-020 transparent SHALL be 1 exactly when the rd_index that produced the output was 0, delayed in step with out_valid.
REQ-021 A write SHALL take effect at the next edge.
- A same-cycle read of the same address returns the old value (read-first).
REQ-022 Brightness b SHALL be a 5-bit value in the range 0..16.
- Each output channel = (ch * b) >> 4, computed at CH_W+5 bits and truncated to CH_W.
- b=16 is identity; b=0 gives black.
REQ-023 The fade FSM SHALL have states IDLE, FADE_OUT and FADE_IN.
- In IDLE, fade_start moves to FADE_OUT (fade_dir=0) or FADE_IN (fade_dir=1).
- In FADE_OUT, each frame_tick decrements b by 1; on reaching 0 the FSM returns to IDLE.
- In FADE_IN, each frame_tick increments b by 1; on reaching 16 the FSM returns to IDLE.
REQ-024 fade_done SHALL pulse for exactly one cycle, on the edge the FSM returns to IDLE.
- fade_busy = 1 in FADE_OUT and FADE_IN.
REQ-025 fade_start while busy SHALL be ignored.
REQ-026 fade_start in IDLE with b already at the target SHALL complete on the first frame_tick, with b unchanged.
REQ-027 When fade_start and frame_tick arrive in the same cycle, only the state transition SHALL occur; b is unchanged.
REQ-028 The brightness change SHALL apply to stage 2 on the cycle after b updates; in-flight lookups use the b current at their stage 2.

Reset
REQ-029 While Reset_n=0 at an edge, the block SHALL clear:
- all palette entries to 0;
- b to 16;
- the FSM to IDLE;
- out_valid, transparent, fade_busy and fade_done to 0;
- red, green and blue to 0.
REQ-030 A reset mid-fade or mid-pipeline SHALL discard all in-flight lookups and fade progress.

Configuration
REQ-031 Macro PALETTE_FADE_EN SHALL control the fade feature.
- Defined: the fade FSM and multiply are built as specified above.
- Undefined: b is constant 16, fade_busy and fade_done are tied 0, fade inputs are ignored, and lookup latency stays 2 cycles.

Structure
REQ-032 Package sprite_palette_pkg SHALL hold:
- the fade-state enum;
- the BRIGHT_MAX=16 constant;
- the rgb_t packed-struct typedef parameterised via CH_W defaults.
REQ-033 Sub-module palette_scale SHALL implement the per-channel brightness multiply, with three instances.

Verification
REQ-034 Reset scenario: reset, then read pal 0 idx 5 -> after 2 cycles, out_valid=1 and RGB=0,0,0 with transparent=0.
REQ-035 Write-then-read scenario: write pal 2 idx 7 = 12'hABC, then read the next cycle -> 2 cycles later, RGB=A,B,C; a same-cycle read of that address returns the old value 0.
REQ-036 Streaming scenario: 16 back-to-back reads of idx 0..15 -> 16 consecutive out_valid cycles in order, with transparent=1 only for the first.
REQ-037 Fade-out scenario: entry 12'hFFF, fade_dir=0, then 8 frame_ticks -> b=8 and output 7,7,7; after 16 ticks, output 0,0,0, with fade_done pulsed once and fade_busy=0.
REQ-038 Busy and collision scenario: fade_start during FADE_IN -> ignored; fade_start together with frame_tick -> b unchanged that cycle.
REQ-039 Build scenario: compile without PALETTE_FADE_EN and issue fade_start plus 20 frame_ticks -> 12'hFFF still reads F,F,F, and fade_busy and fade_done stay 0.
